serial_frame_tx: RTL

- Behavioural parallel-to-serial transmitter.
- Accepts one DATA_W-bit word through a valid/ready handshake and shifts it out on a single line.
- Frame format: one start bit, DATA_W data bits LSB first, one stop bit.
- All state is held in negative-edge-triggered registers, matching the existing D_FF storage elements. It is the sending end of the serial capture chain built from those flops.

---
 rtl/serial_pkg.sv | 17 +
 rtl/tx_shift_reg.sv | 35 +++
 rtl/serial_frame_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line levels for the serial frame transmitter
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DEF_DATA_W = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_shift_reg.sv
// rtl/tx_shift_reg.sv - negedge parallel-load shift-right register, LSB exposed for the serial line
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic              lsb
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift_en) begin
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
        end
    end

    always_ff @(negedge clock) begin
        if (clear) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign lsb = shreg_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - start/data(LSB first)/stop frame transmitter with valid/ready load
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int             CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_W);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          serial_q, serial_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_en, shift_en, sh_lsb;
    logic          accept;

    assign accept = (state_q == IDLE) && load_valid && ready_q;

    tx_shift_reg #(.DATA_W(DATA_W)) u_shreg (
        .clock    (clock),
        .clear    (clear),
        .load     (load_en),
        .shift_en (shift_en),
        .din      (data_in),
        .lsb      (sh_lsb)
    );

    always_ff @(negedge clock) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA:    if (cnt_q >= CNT_LAST) state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the line always comes from a flop.
    always_comb begin
        cnt_d    = cnt_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_en  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d = LINE_IDLE;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                if (accept) begin
                    load_en  = 1'b1;
                    serial_d = START_BIT;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            START: begin
                serial_d = sh_lsb;
                shift_en = 1'b1;
                cnt_d    = CW'(1);
            end
            DATA: begin
                if (cnt_q < CNT_LAST) begin
                    serial_d = sh_lsb;
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end else begin
                    serial_d = STOP_BIT;
                end
            end
            STOP: begin
                serial_d = LINE_IDLE;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
            default: begin
                serial_d = LINE_IDLE;
            end
        endcase
    end

    always_ff @(negedge clock) begin
        if (clear) begin
            cnt_q    <= '0;
            serial_q <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign load_ready = ready_q;
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
